// File: rtl/regwrite_arbiter_m.sv
// Round-robin arbiter merging ALU (A) and load (B) writebacks onto one register-file
// write port; writes to XZR (register 31) are discarded and counted.
module regwrite_arbiter_m (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        aValid,
  input  logic [4:0]  aReg,
  input  logic [31:0] aData,
  output logic        aReady,
  input  logic        bValid,
  input  logic [4:0]  bReg,
  input  logic [31:0] bData,
  output logic        bReady,
  input  logic        stall,
  output logic        RegWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  output logic [7:0]  dropCount
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        prio_r;
  logic        a_grant_s;
  logic        b_grant_s;
  logic        xfer_s;
  logic [4:0]  sel_reg_s;
  logic [31:0] sel_data_s;

  // Grant selection; the reset_n term keeps both readys low during reset.
  always_comb begin
    a_grant_s = 1'b0;
    b_grant_s = 1'b0;
    if (reset_n && !stall) begin
      if (aValid && bValid) begin
        if (prio_r) begin
          b_grant_s = 1'b1;
        end else begin
          a_grant_s = 1'b1;
        end
      end else if (aValid) begin
        a_grant_s = 1'b1;
      end else if (bValid) begin
        b_grant_s = 1'b1;
      end else begin
        a_grant_s = 1'b0;
      end
    end else begin
      a_grant_s = 1'b0;
    end
  end

  assign aReady     = a_grant_s;
  assign bReady     = b_grant_s;
  assign xfer_s     = a_grant_s | b_grant_s;
  assign sel_reg_s  = b_grant_s ? bReg  : aReg;
  assign sel_data_s = b_grant_s ? bData : aData;

  // Next-state logic of the write-enable machine.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_WRITE: begin
        if (xfer_s && (sel_reg_s != 5'd31)) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign RegWrite = (state_r == ST_WRITE);

  // Priority pointer, captured write target/data and XZR drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_r        <= 1'b0;
      writeRegister <= 5'd0;
      writeData     <= 32'd0;
      dropCount     <= 8'd0;
    end else if (xfer_s) begin
      prio_r        <= a_grant_s;
      writeRegister <= sel_reg_s;
      writeData     <= sel_data_s;
      if ((sel_reg_s == 5'd31) && (dropCount != 8'd255)) begin
        dropCount <= dropCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter_m.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_regwrite_arbiter_m;

  logic        clk;
  logic        reset_n;
  logic        aValid;
  logic [4:0]  aReg;
  logic [31:0] aData;
  logic        aReady;
  logic        bValid;
  logic [4:0]  bReg;
  logic [31:0] bData;
  logic        bReady;
  logic        stall;
  logic        RegWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [7:0]  dropCount;

  int n_vec = 0;
  int n_err = 0;

  regwrite_arbiter_m dut (
    .clk(clk), .reset_n(reset_n),
    .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
    .stall(stall), .RegWrite(RegWrite), .writeRegister(writeRegister),
    .writeData(writeData), .dropCount(dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who gets the port this cycle, and what the write port shows next cycle.
  logic        m_prio;   // 0 = A first, 1 = B first
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_drops;

  function automatic logic [1:0] who_wins(input logic av, input logic bv, input logic st,
                                          input logic rn, input logic pr);
    if (!rn || st) return 2'b00;
    if (av && bv)  return pr ? 2'b10 : 2'b01;
    return {bv, av & ~bv};
  endfunction

  logic [1:0]  m_win;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  assign m_win  = who_wins(aValid, bValid, stall, reset_n, m_prio);
  assign m_reg  = m_win[1] ? bReg  : aReg;
  assign m_data = m_win[1] ? bData : aData;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prio  <= 1'b0;
      m_rw    <= 1'b0;
      m_wreg  <= 5'd0;
      m_wdata <= 32'd0;
      m_drops <= 0;
    end else if (m_win != 2'b00) begin
      m_prio  <= m_win[0];
      m_wreg  <= m_reg;
      m_wdata <= m_data;
      m_rw    <= (m_reg != 5'd31);
      if (m_reg == 5'd31) m_drops <= (m_drops >= 255) ? 255 : m_drops + 1;
    end else begin
      m_rw <= 1'b0;
    end
  end

  // Continuous comparison against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_aReady",   32'(aReady),        32'(m_win[0]));
      chk("m_bReady",   32'(bReady),        32'(m_win[1]));
      chk("m_RegWrite", 32'(RegWrite),      32'(m_rw));
      chk("m_wreg",     32'(writeRegister), 32'(m_wreg));
      chk("m_wdata",    writeData,          m_wdata);
      chk("m_drops",    32'(dropCount),     32'(m_drops));
    end
  end

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic st);
    aValid = av; aReg = ar; aData = ad;
    bValid = bv; bReg = br; bData = bd;
    stall  = st;
  endtask

  // Edge then settle: registered outputs are stable 1 time unit after the edge.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_wreg",     32'(writeRegister), 32'd0);
    chk("rst_wdata",    writeData, 32'd0);
    chk("rst_drops",    32'(dropCount), 32'd0);
    chk("rst_readys",   32'({aReady, bReady}), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Single A request.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    chk("a_single_ready", 32'(aReady), 32'd1);
    edge1();
    chk("a_single_rw",   32'(RegWrite), 32'd1);
    chk("a_single_reg",  32'(writeRegister), 32'd5);
    chk("a_single_data", writeData, 32'h1234);
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    edge1();
    chk("a_single_rw_off", 32'(RegWrite), 32'd0);

    // Contention from reset: A,B,A,B.
    do_reset();
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk("cont_rw",  32'(RegWrite), 32'd1);
      chk("cont_reg", 32'(writeRegister), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

    // XZR drops and saturation.
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0);
    edge1();
    chk("xzr_rw",    32'(RegWrite), 32'd0);
    chk("xzr_reg",   32'(writeRegister), 32'd31);
    chk("xzr_data",  writeData, 32'hFFFF_FFFF);
    chk("xzr_drops", 32'(dropCount), 32'd1);
    repeat (299) @(posedge clk);
    #1;
    chk("xzr_sat", 32'(dropCount), 32'd255);
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Stall: drains the prior write, then resumes with held priority (B).
    do_reset();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0);
    edge1();
    #1;
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b1);
    #1;
    chk("stall_readys", 32'({aReady, bReady}), 32'd0);
    chk("stall_drain",  32'(RegWrite), 32'd1);
    edge1();
    chk("stall_rw2", 32'(RegWrite), 32'd0);
    edge1();
    chk("stall_rw3", 32'(RegWrite), 32'd0);
    #1;
    stall = 1'b0;
    #1;
    chk("resume_b", 32'({aReady, bReady}), 32'd1);
    edge1();
    chk("resume_reg", 32'(writeRegister), 32'd6);
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Reset in the cycle after an A transfer to reg 7.
    edge1();
    #1;
    drive(1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0, 1'b0);
    edge1();
    chk("mid_rw", 32'(RegWrite), 32'd1);
    #1;
    drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h9, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rw",   32'(RegWrite), 32'd0);
    chk("mid_rst_reg",  32'(writeRegister), 32'd0);
    chk("mid_rst_data", writeData, 32'd0);
    chk("mid_rst_rdy",  32'({aReady, bReady}), 32'd0);
    edge1();
    chk("mid_rst_nopulse", 32'(RegWrite), 32'd0);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_a_first", 32'({aReady, bReady}), 32'd2);
    edge1();
    chk("post_rst_reg", 32'(writeRegister), 32'd8);

    // Randomized traffic, occasional async reset.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      r = $urandom;
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if (r[31:24] == 8'd0) begin
        reset_n = 1'b0;
      end
      aValid = r[0];
      bValid = r[1];
      stall  = (r[4:2] == 3'd0);
      aReg   = (r[7:5] == 3'd0) ? 5'd31 : r[12:8];
      bReg   = (r[15:13] == 3'd0) ? 5'd31 : r[20:16];
      aData  = $urandom;
      bData  = $urandom;
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
